// File: rtl/regfile_microseq_pkg.sv
// Shared types, opcode/FunSel encodings and decode helpers for the RegFile micro-sequencer.
package regfile_microseq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StDone
    } state_e;

    localparam logic [3:0] OpNop    = 4'd0;
    localparam logic [3:0] OpLdi    = 4'd1;
    localparam logic [3:0] OpInc    = 4'd2;
    localparam logic [3:0] OpDec    = 4'd3;
    localparam logic [3:0] OpClr    = 4'd4;
    localparam logic [3:0] OpMov    = 4'd5;
    localparam logic [3:0] OpClrAll = 4'd6;

    localparam logic [1:0] FunDec   = 2'b00;
    localparam logic [1:0] FunInc   = 2'b01;
    localparam logic [1:0] FunLoad  = 2'b10;
    localparam logic [1:0] FunClear = 2'b11;

    function automatic logic op_defined(input logic [3:0] op);
        return op <= OpClrAll;
    endfunction

    // Undefined opcodes fall through to DONE, same path as NOP.
    function automatic state_e accept_state(input logic [3:0] op);
        case (op)
            OpNop:                                   return StDone;
            OpMov:                                   return StRead;
            OpLdi, OpInc, OpDec, OpClr, OpClrAll:    return StExec;
            default:                                 return StDone;
        endcase
    endfunction

endpackage

// File: rtl/regfile_microseq_onehot.sv
// 2->4 write-enable decoder; all_i forces every enable on (CLRALL).
module regfile_microseq_onehot (
    input  logic [1:0] sel_i,
    input  logic       all_i,
    output logic [3:0] onehot_o
);

    always_comb begin
        onehot_o = 4'b0000;
        if (all_i) begin
            onehot_o = 4'b1111;
        end else begin
            unique case (sel_i)
                2'd0: onehot_o = 4'b0001;
                2'd1: onehot_o = 4'b0010;
                2'd2: onehot_o = 4'b0100;
                2'd3: onehot_o = 4'b1000;
                default: onehot_o = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/regfile_microseq.sv
// Micro-op sequencer driving RegFile controls from one accepted instruction at a time.
// Optional: define MICROSEQ_ILLEGAL_TRAP_EN to flag undefined opcodes on a sticky illegal output.
module regfile_microseq
    import regfile_microseq_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         instr_valid,
    input  logic [W+7:0] instr,
    output logic         instr_ready,
    input  logic [W-1:0] rf_outa,
    output logic [3:0]   RegSel,
    output logic [1:0]   FunSel,
    output logic [1:0]   OutASel,
    output logic [1:0]   OutBSel,
    output logic [W-1:0] I,
    output logic         busy,
    output logic         done,
    output logic         illegal
);

    state_e       state_q;
    logic [W+7:0] ir_q;
    logic [3:0]   cnt_q;
    logic [W-1:0] mdata_q;

    logic [3:0]   in_op;
    logic [3:0]   op_q;
    logic [1:0]   rd_q;
    logic [1:0]   rs_q;
    logic [W-1:0] imm_q;
    logic [3:0]   wr_sel;

    assign in_op = instr[W+7:W+4];
    assign op_q  = ir_q[W+7:W+4];
    assign rd_q  = ir_q[W+3:W+2];
    assign rs_q  = ir_q[W+1:W];
    assign imm_q = ir_q[W-1:0];

`ifdef MICROSEQ_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            ir_q    <= '0;
            cnt_q   <= '0;
            mdata_q <= '0;
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        ir_q    <= instr;
                        cnt_q   <= (in_op == OpInc || in_op == OpDec) ? instr[3:0] : 4'd0;
                        state_q <= accept_state(in_op);
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
                        if (!op_defined(in_op)) illegal_q <= 1'b1;
`endif
                    end
                end
                StRead: begin
                    mdata_q <= rf_outa;
                    state_q <= StExec;
                end
                StExec: begin
                    if (cnt_q == 4'd0) state_q <= StDone;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    regfile_microseq_onehot u_onehot (
        .sel_i    (rd_q),
        .all_i    (op_q == OpClrAll),
        .onehot_o (wr_sel)
    );

    always_comb begin
        RegSel  = 4'b0000;
        FunSel  = FunDec;
        OutASel = 2'b00;
        OutBSel = 2'b00;
        I       = '0;
        case (state_q)
            StRead: begin
                OutASel = rs_q;
                OutBSel = rd_q;
            end
            StExec: begin
                RegSel  = wr_sel;
                OutBSel = rd_q;
                case (op_q)
                    OpInc:             FunSel = FunInc;
                    OpLdi, OpMov:      FunSel = FunLoad;
                    OpClr, OpClrAll:   FunSel = FunClear;
                    default:           FunSel = FunDec;
                endcase
                if (op_q == OpLdi)      I = imm_q;
                else if (op_q == OpMov) I = mdata_q;
            end
            default: ;
        endcase
    end

    assign instr_ready = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_regfile_microseq.sv
// Directed bench for regfile_microseq with a behavioural RegFile model on its outputs.
module tb_regfile_microseq;

    logic        CLK;
    logic        RST_N;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [7:0]  rf_outa;
    logic [3:0]  RegSel;
    logic [1:0]  FunSel;
    logic [1:0]  OutASel;
    logic [1:0]  OutBSel;
    logic [7:0]  I;
    logic        busy;
    logic        done;
    logic        illegal;

    int checks;
    int fails;
    int cyc;
    int acc_n;
    int acc_last;
    int acc_prev;

    logic [7:0] rf [4];

`ifdef MICROSEQ_ILLEGAL_TRAP_EN
    localparam logic ExpIllegal = 1'b1;
`else
    localparam logic ExpIllegal = 1'b0;
`endif

    regfile_microseq #(.W(8)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_outa     (rf_outa),
        .RegSel      (RegSel),
        .FunSel      (FunSel),
        .OutASel     (OutASel),
        .OutBSel     (OutBSel),
        .I           (I),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RegFile model: not reset by the sequencer's RST_N.
    assign rf_outa = rf[OutASel];
    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (RegSel[i]) begin
                case (FunSel)
                    2'b00: rf[i] <= rf[i] - 8'd1;
                    2'b01: rf[i] <= rf[i] + 8'd1;
                    2'b10: rf[i] <= I;
                    2'b11: rf[i] <= 8'h00;
                endcase
            end
        end
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST_N && instr_valid && instr_ready) begin
            acc_prev <= acc_last;
            acc_last <= cyc;
            acc_n    <= acc_n + 1;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!instr_ready && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (!instr_ready) begin
            checks++; fails++;
            $display("FAIL wait_idle_timeout: ready=%b want 1", instr_ready);
        end
    endtask

    // Presents one instruction; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] ins);
        wait_idle();
        instr_valid = 1'b1;
        instr       = ins;
        @(negedge CLK);
        instr_valid = 1'b0;
        instr       = 16'h0000;
    endtask

    task automatic test_reset();
        checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (RegSel !== 4'b0000) begin fails++; $display("FAIL rst_regsel: got %b want 0000", RegSel); end
        checks++; if (FunSel !== 2'b00 || I !== 8'h00) begin fails++; $display("FAIL rst_fun_i: got %b/%h want 00/00", FunSel, I); end
        checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL rst_illegal: got %b want 0", illegal); end
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_ldi();
        send(16'h18AA);
        checks++; if (RegSel !== 4'b0100) begin fails++; $display("FAIL ldi_regsel: got %b want 0100", RegSel); end
        checks++; if (FunSel !== 2'b10) begin fails++; $display("FAIL ldi_funsel: got %b want 10", FunSel); end
        checks++; if (I !== 8'hAA) begin fails++; $display("FAIL ldi_i: got %h want aa", I); end
        checks++; if (busy !== 1'b1 || instr_ready !== 1'b0) begin fails++; $display("FAIL ldi_busy: got %b/%b want 1/0", busy, instr_ready); end
        checks++; if (OutBSel !== 2'd2) begin fails++; $display("FAIL ldi_outbsel: got %0d want 2", OutBSel); end
        @(negedge CLK);
        checks++; if (done !== 1'b1 || RegSel !== 4'b0000) begin fails++; $display("FAIL ldi_done: got %b/%b want 1/0000", done, RegSel); end
        @(negedge CLK);
        checks++; if (instr_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL ldi_ready_after: got %b%b%b want 100", instr_ready, done, busy); end
        checks++; if (rf[2] !== 8'hAA) begin fails++; $display("FAIL ldi_r2: got %h want aa", rf[2]); end
    endtask

    task automatic test_inc_dec();
        int n;
        int k;
        send(16'h1405);
        send(16'h2403);
        n = 0; k = 0;
        while (!instr_ready && k < 40) begin
            if (RegSel === 4'b0010 && FunSel === 2'b01) n++;
            @(negedge CLK);
            k++;
        end
        checks++; if (n !== 4) begin fails++; $display("FAIL inc_cycles: got %0d want 4", n); end
        checks++; if (rf[1] !== 8'h09) begin fails++; $display("FAIL inc_r1: got %h want 09", rf[1]); end
        send(16'h1C02);
        send(16'h3C13);
        n = 0; k = 0;
        while (!instr_ready && k < 40) begin
            if (RegSel === 4'b1000 && FunSel === 2'b00) n++;
            @(negedge CLK);
            k++;
        end
        checks++; if (n !== 4) begin fails++; $display("FAIL dec_cycles: got %0d want 4", n); end
        checks++; if (rf[3] !== 8'hFE) begin fails++; $display("FAIL dec_r3_wrap: got %h want fe", rf[3]); end
    endtask

    task automatic test_clr();
        send(16'h4400);
        checks++; if (RegSel !== 4'b0010 || FunSel !== 2'b11) begin fails++; $display("FAIL clr_ctrl: got %b/%b want 0010/11", RegSel, FunSel); end
        wait_idle();
        checks++; if (rf[1] !== 8'h00) begin fails++; $display("FAIL clr_r1: got %h want 00", rf[1]); end
        send(16'h6000);
        checks++; if (RegSel !== 4'b1111 || FunSel !== 2'b11) begin fails++; $display("FAIL clrall_ctrl: got %b/%b want 1111/11", RegSel, FunSel); end
        wait_idle();
        checks++; if (rf[2] !== 8'h00 || rf[3] !== 8'h00) begin fails++; $display("FAIL clrall_regs: got %h/%h want 00/00", rf[2], rf[3]); end
    endtask

    task automatic test_mov();
        send(16'h103C);
        send(16'h5C00);
        checks++; if (OutASel !== 2'd0 || RegSel !== 4'b0000 || busy !== 1'b1) begin fails++; $display("FAIL mov_read: got %0d/%b/%b want 0/0000/1", OutASel, RegSel, busy); end
        checks++; if (OutBSel !== 2'd3) begin fails++; $display("FAIL mov_outbsel: got %0d want 3", OutBSel); end
        @(negedge CLK);
        checks++; if (RegSel !== 4'b1000 || FunSel !== 2'b10 || I !== 8'h3C) begin fails++; $display("FAIL mov_exec: got %b/%b/%h want 1000/10/3c", RegSel, FunSel, I); end
        wait_idle();
        checks++; if (rf[3] !== 8'h3C) begin fails++; $display("FAIL mov_r3: got %h want 3c", rf[3]); end
        send(16'h5B00);
        checks++; if (OutASel !== 2'd3) begin fails++; $display("FAIL mov2_outasel: got %0d want 3", OutASel); end
        @(negedge CLK);
        checks++; if (RegSel !== 4'b0100 || I !== 8'h3C) begin fails++; $display("FAIL mov2_exec: got %b/%h want 0100/3c", RegSel, I); end
        wait_idle();
        checks++; if (rf[2] !== 8'h3C) begin fails++; $display("FAIL mov2_r2: got %h want 3c", rf[2]); end
    endtask

    task automatic test_back_to_back();
        int a0;
        int k;
        wait_idle();
        a0 = acc_n;
        instr_valid = 1'b1;
        instr       = 16'h1011;
        @(negedge CLK);
        instr = 16'h1422;
        k = 0;
        while (acc_n < a0 + 2 && k < 20) begin @(negedge CLK); k++; end
        instr_valid = 1'b0;
        checks++; if (acc_n !== a0 + 2 || acc_last - acc_prev !== 3) begin fails++; $display("FAIL b2b_ldi_gap: got n=%0d gap=%0d want n=%0d gap=3", acc_n - a0, acc_last - acc_prev, 2); end
        wait_idle();
        checks++; if (rf[0] !== 8'h11 || rf[1] !== 8'h22) begin fails++; $display("FAIL b2b_regs: got %h/%h want 11/22", rf[0], rf[1]); end
        a0 = acc_n;
        instr_valid = 1'b1;
        instr       = 16'h0000;
        @(negedge CLK);
        instr = 16'h1433;
        k = 0;
        while (acc_n < a0 + 2 && k < 20) begin @(negedge CLK); k++; end
        instr_valid = 1'b0;
        checks++; if (acc_n !== a0 + 2 || acc_last - acc_prev !== 2) begin fails++; $display("FAIL b2b_nop_gap: got n=%0d gap=%0d want n=2 gap=2", acc_n - a0, acc_last - acc_prev); end
        wait_idle();
    endtask

    task automatic test_reset_midop();
        int n;
        send(16'h1850);
        send(16'h280F);
        @(negedge CLK);
        @(negedge CLK);
        #1 RST_N = 1'b0;
        #1;
        checks++; if (RegSel !== 4'b0000 || FunSel !== 2'b00) begin fails++; $display("FAIL rstmid_ctrl: got %b/%b want 0000/00", RegSel, FunSel); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b1) begin fails++; $display("FAIL rstmid_state: got %b%b%b want 001", busy, done, instr_ready); end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (RegSel !== 4'b0000) n++;
        end
        checks++; if (n !== 0) begin fails++; $display("FAIL rstmid_no_write: got %0d cycles want 0", n); end
        checks++; if (rf[2] !== 8'h52) begin fails++; $display("FAIL rstmid_r2: got %h want 52", rf[2]); end
    endtask

    task automatic test_illegal();
        send(16'hF000);
        checks++; if (done !== 1'b1 || RegSel !== 4'b0000) begin fails++; $display("FAIL ill_done: got %b/%b want 1/0000", done, RegSel); end
        checks++; if (illegal !== ExpIllegal) begin fails++; $display("FAIL ill_flag: got %b want %b", illegal, ExpIllegal); end
        send(16'h1077);
        checks++; if (RegSel !== 4'b0001 || I !== 8'h77) begin fails++; $display("FAIL ill_next_exec: got %b/%h want 0001/77", RegSel, I); end
        checks++; if (illegal !== ExpIllegal) begin fails++; $display("FAIL ill_sticky: got %b want %b", illegal, ExpIllegal); end
        wait_idle();
        checks++; if (rf[0] !== 8'h77) begin fails++; $display("FAIL ill_r0: got %h want 77", rf[0]); end
        RST_N = 1'b0;
        #1;
        checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL ill_reset_clear: got %b want 0", illegal); end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        RST_N       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        repeat (2) @(negedge CLK);
        test_reset();
        test_ldi();
        test_inc_dec();
        test_clr();
        test_mov();
        test_back_to_back();
        test_reset_midop();
        test_illegal();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
